// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I core: one word-addressed RAM
// behind valid/ready request and response channels, with programmable wait states.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               accept;
    logic               ram_we;
    logic               rsp_valid_next, rsp_err_next;
    logic [31:0]        rsp_rdata_next;
    logic               req_ready_next, busy_next;

    logic               write_q;
    logic [31:0]        addr_q, wdata_q;
    logic [3:0]         be_q;

    logic [31:0]        mem [DEPTH_WORDS];

    // Address decode of the latched request
    logic [31:0]        word_off;
    logic [AW-1:0]      idx;
    logic               acc_err;

    assign word_off = (addr_q - BASE_ADDR) >> 2;
    assign idx      = word_off[AW-1:0];
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR)
                      || (word_off >= 32'(DEPTH_WORDS));

    // Next-state and next-output logic
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        accept         = 1'b0;
        ram_we         = 1'b0;
        rsp_valid_next = rsp_valid;
        rsp_rdata_next = rsp_rdata;
        rsp_err_next   = rsp_err;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_ACCESS;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_next = CNT_W'(cnt - CNT_W'(1));
                if (cnt <= CNT_W'(1)) state_next = S_ACCESS;
            end
            S_ACCESS: begin
                state_next     = S_RESP;
                rsp_err_next   = acc_err;
                rsp_rdata_next = (write_q || acc_err) ? 32'h0 : mem[idx];
                ram_we         = write_q && !acc_err;
            end
            S_RESP: begin
                // Response register stage: valid rises one cycle after ACCESS
                if (!rsp_valid) begin
                    rsp_valid_next = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        req_ready_next = (state_next == S_IDLE);
        busy_next      = (state_next != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_ready <= req_ready_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            rsp_err   <= rsp_err_next;
            busy      <= busy_next;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // RAM array; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule
